// File: rtl/ahb3lite_pkg.sv
// Shared AHB3-Lite types and constants for the memory slave.
package ahb3lite_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned WCNT_W = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        BUSY   = 2'b01,
        NONSEQ = 2'b10,
        SEQ    = 2'b11
    } HTRANS_state;

    typedef enum logic [2:0] {
        SINGLE = 3'b000,
        INCR   = 3'b001
    } HBURST_Type;

    typedef enum logic {
        OKAY  = 1'b0,
        ERROR = 1'b1
    } HRESP_state;

    localparam logic [2:0] WORD  = 3'b010;
    localparam logic       READ  = 1'b0;
    localparam logic       WRITE = 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_DATA,
        S_ERR1,
        S_ERR2
    } ahb_slave_state;

    function automatic logic is_active(HTRANS_state t);
        return (t == NONSEQ) || (t == SEQ);
    endfunction

endpackage

// File: rtl/ahb3lite_mem_slave_if.sv
// AHB3-Lite bus bundle between one master and the memory slave.
interface ahb3lite_mem_slave_if;
    import ahb3lite_pkg::*;

    logic                HSEL;
    logic [ADDR_W-1:0]   HADDR;
    HTRANS_state         HTRANS;
    logic                HWRITE;
    logic [2:0]          HSIZE;
    HBURST_Type          HBURST;
    logic [DATA_W-1:0]   HWDATA;
    logic                HREADY;
    HRESP_state          HRESP;
    logic [DATA_W-1:0]   HRDATA;
    logic                HRDATA_En;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HREADY, HRESP, HRDATA, HRDATA_En
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HREADY, HRESP, HRDATA, HRDATA_En
    );

endinterface

// File: rtl/ahb3lite_sp_ram.sv
// Word memory: one synchronous write port, one asynchronous read port, no reset.
module ahb3lite_sp_ram
    import ahb3lite_pkg::*;
#(
    parameter int unsigned DEPTH_W = 6
) (
    input  logic               clk,
    input  logic               we,
    input  logic [DEPTH_W-1:0] waddr,
    input  logic [DATA_W-1:0]  wdata,
    input  logic [DEPTH_W-1:0] raddr,
    output logic [DATA_W-1:0]  rdata
);

    logic [DATA_W-1:0] mem [2**DEPTH_W];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/ahb3lite_mem_slave.sv
// AHB3-Lite word-addressed memory slave with programmable wait states and
// two-cycle ERROR response for illegal size or out-of-window addresses.
module ahb3lite_mem_slave
    import ahb3lite_pkg::*;
#(
    parameter int unsigned       DEPTH_W     = 6,
    parameter int unsigned       WAIT_STATES = 0,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 32'h0
) (
    input  logic                 HCLK,
    input  logic                 HRESET,
    ahb3lite_mem_slave_if.slave  bus
);

    ahb_slave_state       state;
    logic [DEPTH_W-1:0]   idx_q;
    logic                 write_q;
    logic [WCNT_W-1:0]    wait_cnt;

    logic [ADDR_W:0]      diff_c;
    logic [ADDR_W-1:0]    offset_c;
    logic                 illegal_c;
    logic                 accept_c;
    logic [DEPTH_W-1:0]   new_idx_c;
    logic [DEPTH_W-1:0]   rd_idx_c;
    logic                 ram_we_c;
    logic [DATA_W-1:0]    ram_rdata;
    logic [DATA_W-1:0]    rd_data_c;

    // Address decode; the extra diff bit is the borrow flagging HADDR below the window.
    always_comb begin
        diff_c    = {1'b0, bus.HADDR} - {1'b0, BASE_ADDR};
        offset_c  = diff_c[ADDR_W-1:0];
        illegal_c = (bus.HSIZE != WORD) || diff_c[ADDR_W] || ((offset_c >> DEPTH_W) != '0);
        accept_c  = bus.HSEL && is_active(bus.HTRANS) && bus.HREADY &&
                    ((state == S_IDLE) || (state == S_DATA));
        new_idx_c = offset_c[DEPTH_W-1:0];
        rd_idx_c  = (state == S_WAIT) ? idx_q : new_idx_c;
        ram_we_c  = (state == S_DATA) && (write_q == WRITE) && !HRESET;
        // A pipelined read of the word being written this edge sees the new data.
        rd_data_c = (ram_we_c && (idx_q == rd_idx_c)) ? bus.HWDATA : ram_rdata;
    end

    ahb3lite_sp_ram #(
        .DEPTH_W (DEPTH_W)
    ) u_ram (
        .clk   (HCLK),
        .we    (ram_we_c),
        .waddr (idx_q),
        .wdata (bus.HWDATA),
        .raddr (rd_idx_c),
        .rdata (ram_rdata)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state         <= S_IDLE;
            idx_q         <= '0;
            write_q       <= READ;
            wait_cnt      <= '0;
            bus.HREADY    <= 1'b1;
            bus.HRESP     <= OKAY;
            bus.HRDATA    <= '0;
            bus.HRDATA_En <= 1'b0;
        end else begin
            bus.HRDATA_En <= 1'b0;
            case (state)
                S_IDLE, S_DATA: begin
                    if (accept_c) begin
                        idx_q   <= new_idx_c;
                        write_q <= bus.HWRITE;
                        if (illegal_c) begin
                            state      <= S_ERR1;
                            bus.HREADY <= 1'b0;
                            bus.HRESP  <= ERROR;
                        end else if (WAIT_STATES != 0) begin
                            state      <= S_WAIT;
                            wait_cnt   <= WCNT_W'(WAIT_STATES - 1);
                            bus.HREADY <= 1'b0;
                            bus.HRESP  <= OKAY;
                        end else begin
                            state      <= S_DATA;
                            bus.HREADY <= 1'b1;
                            bus.HRESP  <= OKAY;
                            if (bus.HWRITE == READ) begin
                                bus.HRDATA    <= rd_data_c;
                                bus.HRDATA_En <= 1'b1;
                            end
                        end
                    end else begin
                        state      <= S_IDLE;
                        bus.HREADY <= 1'b1;
                        bus.HRESP  <= OKAY;
                    end
                end
                S_WAIT: begin
                    if (wait_cnt == '0) begin
                        state      <= S_DATA;
                        bus.HREADY <= 1'b1;
                        if (write_q == READ) begin
                            bus.HRDATA    <= rd_data_c;
                            bus.HRDATA_En <= 1'b1;
                        end
                    end else begin
                        wait_cnt <= wait_cnt - WCNT_W'(1);
                    end
                end
                S_ERR1: begin
                    state      <= S_ERR2;
                    bus.HREADY <= 1'b1;
                end
                S_ERR2: begin
                    state     <= S_IDLE;
                    bus.HRESP <= OKAY;
                end
                default: begin
                    state      <= S_IDLE;
                    bus.HREADY <= 1'b1;
                    bus.HRESP  <= OKAY;
                end
            endcase
        end
    end

endmodule
